// File: rtl/reorder_buffer_if.sv
// Issue / CDB / query / commit / flush signal bundle between the Tomasulo core
// and its reorder buffer. master = core side, slave = reorder buffer.
interface reorder_buffer_if #(
  parameter int unsigned IDX_W = 6
);
  logic             issue_valid;
  logic             issue_has_rd;
  logic [4:0]       issue_rd;
  logic             issue_is_branch;
  logic             issue_pred_taken;
  logic [IDX_W-1:0] issue_index;
  logic             rob_full;

  logic             cdb_valid;
  logic [IDX_W-1:0] cdb_index;
  logic [31:0]      cdb_value;
  logic             cdb_taken;
  logic [31:0]      cdb_target;

  logic [IDX_W-1:0] query1_index;
  logic             query1_ready;
  logic [31:0]      query1_value;
  logic [IDX_W-1:0] query2_index;
  logic             query2_ready;
  logic [31:0]      query2_value;

  logic             commit_valid;
  logic [IDX_W-1:0] commit_index;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_value;
  logic             flush;
  logic [31:0]      flush_pc;

  modport master (
    output issue_valid, issue_has_rd, issue_rd, issue_is_branch, issue_pred_taken,
    input  issue_index, rob_full,
    output cdb_valid, cdb_index, cdb_value, cdb_taken, cdb_target,
    output query1_index, query2_index,
    input  query1_ready, query1_value, query2_ready, query2_value,
    input  commit_valid, commit_index, commit_rd, commit_value, flush, flush_pc
  );

  modport slave (
    input  issue_valid, issue_has_rd, issue_rd, issue_is_branch, issue_pred_taken,
    output issue_index, rob_full,
    input  cdb_valid, cdb_index, cdb_value, cdb_taken, cdb_target,
    input  query1_index, query2_index,
    output query1_ready, query1_value, query2_ready, query2_value,
    output commit_valid, commit_index, commit_rd, commit_value, flush, flush_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order CDB writeback,
// in-order retirement to the register file, flush on a mispredicted branch at head.
module reorder_buffer #(
  parameter int unsigned IDX_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  reorder_buffer_if.slave rob
);
  localparam int unsigned    DEPTH      = 1 << IDX_W;
  localparam logic [IDX_W:0] FULL_COUNT = {1'b1, {IDX_W{1'b0}}};

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;

  logic             has_rd_q     [DEPTH];
  logic [4:0]       rd_q         [DEPTH];
  logic             is_branch_q  [DEPTH];
  logic             pred_taken_q [DEPTH];
  logic [31:0]      value_q      [DEPTH];
  logic             taken_q      [DEPTH];
  logic [31:0]      target_q     [DEPTH];

  logic             commit_valid_q;
  logic [IDX_W-1:0] commit_index_q;
  logic [4:0]       commit_rd_q;
  logic [31:0]      commit_value_q;
  logic             flush_q;
  logic [31:0]      flush_pc_q;

  logic full;
  logic alloc;
  logic writeback;
  logic retire;
  logic mispredict;
  logic commit_write;
  logic q1_hit;
  logic q2_hit;

  always_comb begin
    full         = (count == FULL_COUNT);
    alloc        = rob.issue_valid && !full && !flush_q;
    writeback    = rob.cdb_valid && busy[rob.cdb_index] && !flush_q;
    retire       = (count != '0) && ready[head] && !flush_q;
    mispredict   = retire && is_branch_q[head] && (taken_q[head] != pred_taken_q[head]);
    commit_write = has_rd_q[head] && (rd_q[head] != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      busy           <= '0;
      ready          <= '0;
      commit_valid_q <= 1'b0;
      commit_index_q <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else if (rdy) begin
      flush_q        <= 1'b0;
      commit_valid_q <= 1'b0;
      if (alloc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + IDX_W'(1);
      end
      if (writeback) begin
        ready[rob.cdb_index] <= 1'b1;
      end
      // Mispredict is written last so it wipes any allocation made on the same edge.
      if (mispredict) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        busy       <= '0;
        ready      <= '0;
        flush_q    <= 1'b1;
        flush_pc_q <= target_q[head];
      end else begin
        if (retire) begin
          busy[head]     <= 1'b0;
          ready[head]    <= 1'b0;
          head           <= head + IDX_W'(1);
          commit_valid_q <= commit_write;
          commit_index_q <= head;
          commit_rd_q    <= rd_q[head];
          commit_value_q <= value_q[head];
        end
        if (alloc && !retire) begin
          count <= count + (IDX_W+1)'(1);
        end else if (!alloc && retire) begin
          count <= count - (IDX_W+1)'(1);
        end
      end
    end
  end

  // Entry payload needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (alloc) begin
        has_rd_q[tail]     <= rob.issue_has_rd;
        rd_q[tail]         <= rob.issue_rd;
        is_branch_q[tail]  <= rob.issue_is_branch;
        pred_taken_q[tail] <= rob.issue_pred_taken;
      end
      if (writeback) begin
        value_q[rob.cdb_index]  <= rob.cdb_value;
        taken_q[rob.cdb_index]  <= rob.cdb_taken;
        target_q[rob.cdb_index] <= rob.cdb_target;
      end
    end
  end

  always_comb begin
    q1_hit = rob.cdb_valid && (rob.cdb_index == rob.query1_index);
    q2_hit = rob.cdb_valid && (rob.cdb_index == rob.query2_index);
    rob.query1_ready = busy[rob.query1_index] && (ready[rob.query1_index] || q1_hit);
    rob.query2_ready = busy[rob.query2_index] && (ready[rob.query2_index] || q2_hit);
    if (!busy[rob.query1_index]) begin
      rob.query1_value = '0;
    end else if (q1_hit) begin
      rob.query1_value = rob.cdb_value;
    end else begin
      rob.query1_value = value_q[rob.query1_index];
    end
    if (!busy[rob.query2_index]) begin
      rob.query2_value = '0;
    end else if (q2_hit) begin
      rob.query2_value = rob.cdb_value;
    end else begin
      rob.query2_value = value_q[rob.query2_index];
    end
  end

  assign rob.issue_index  = tail;
  assign rob.rob_full     = full;
  assign rob.commit_valid = commit_valid_q;
  assign rob.commit_index = commit_index_q;
  assign rob.commit_rd    = commit_rd_q;
  assign rob.commit_value = commit_value_q;
  assign rob.flush        = flush_q;
  assign rob.flush_pc     = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed-vector bench for reorder_buffer: in-order commit, full/wrap, mispredict
// flush, silent retire, CDB query bypass, rdy freeze and mid-stream reset.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   vectors = 0;
  int   miscompares = 0;

  reorder_buffer_if #(.IDX_W(6)) bus ();

  reorder_buffer #(.IDX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .rob (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue_valid      = 1'b0;
    bus.issue_has_rd     = 1'b0;
    bus.issue_rd         = '0;
    bus.issue_is_branch  = 1'b0;
    bus.issue_pred_taken = 1'b0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_index        = '0;
    bus.cdb_value        = '0;
    bus.cdb_taken        = 1'b0;
    bus.cdb_target       = '0;
    bus.query1_index     = '0;
    bus.query2_index     = '0;
  endtask

  task automatic cdb(input logic [5:0] idx, input logic [31:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_index = idx;
    bus.cdb_value = val;
  endtask

  task automatic chk_commit(input string tag, input logic v, input logic [5:0] idx,
                            input logic [4:0] rd, input logic [31:0] val);
    chk({tag, ".valid"}, 32'(bus.commit_valid), 32'(v));
    chk({tag, ".index"}, 32'(bus.commit_index), 32'(idx));
    chk({tag, ".rd"},    32'(bus.commit_rd),    32'(rd));
    chk({tag, ".value"}, bus.commit_value,      val);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_commit(tag, 1'b0, 6'd0, 5'd0, 32'h0);
    chk({tag, ".issue_index"}, 32'(bus.issue_index), 32'd0);
    chk({tag, ".rob_full"},    32'(bus.rob_full),    32'd0);
    chk({tag, ".flush"},       32'(bus.flush),       32'd0);
    chk({tag, ".flush_pc"},    bus.flush_pc,         32'h0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    rdy = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_all_zero("reset");

    // Three issues, out-of-order writeback, in-order commit.
    bus.issue_valid  = 1'b1;
    bus.issue_has_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.issue_rd = 5'(i + 1);
      #1;
      chk($sformatf("alloc_idx%0d", i), 32'(bus.issue_index), 32'(i));
      step();
    end
    bus.issue_valid = 1'b0;
    cdb(6'd2, 32'h30); step();
    chk("ooo.nocommit0", 32'(bus.commit_valid), 32'd0);
    cdb(6'd0, 32'h10); step();
    chk("ooo.nocommit1", 32'(bus.commit_valid), 32'd0);
    cdb(6'd1, 32'h20); step();
    chk_commit("ooo.c0", 1'b1, 6'd0, 5'd1, 32'h10);
    bus.cdb_valid = 1'b0; step();
    chk_commit("ooo.c1", 1'b1, 6'd1, 5'd2, 32'h20);
    step();
    chk_commit("ooo.c2", 1'b1, 6'd2, 5'd3, 32'h30);
    step();
    chk("ooo.idle", 32'(bus.commit_valid), 32'd0);

    // rd=0 entry and no-rd entry retire silently; following entry commits from idx5.
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd0;
    #1; chk("silent.idx3", 32'(bus.issue_index), 32'd3);
    step();
    bus.issue_has_rd = 1'b0; bus.issue_rd = 5'd7; step();
    bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd9; step();
    bus.issue_valid = 1'b0;
    cdb(6'd3, 32'h55); step();
    cdb(6'd4, 32'h66); step();
    chk("silent.rd0", 32'(bus.commit_valid), 32'd0);
    cdb(6'd5, 32'h77); step();
    chk("silent.nord", 32'(bus.commit_valid), 32'd0);
    bus.cdb_valid = 1'b0; step();
    chk_commit("silent.after", 1'b1, 6'd5, 5'd9, 32'h77);

    // Fill all 64 entries, overflow issue ignored, retire head wraps tail.
    rst = 1'b1; step(); rst = 0;
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.issue_rd = (i == 0) ? 5'd1 : 5'd2;
      if (i == 63) begin
        #1; chk("full.before", 32'(bus.rob_full), 32'd0);
      end
      step();
    end
    chk("full.set", 32'(bus.rob_full), 32'd1);
    chk("full.tailwrap", 32'(bus.issue_index), 32'd0);
    bus.issue_rd = 5'd31; step();
    bus.issue_valid = 1'b0;
    chk("full.ovf_full", 32'(bus.rob_full), 32'd1);
    chk("full.ovf_idx", 32'(bus.issue_index), 32'd0);
    cdb(6'd0, 32'habc); step();
    bus.cdb_valid = 1'b0; step();
    chk_commit("full.retire", 1'b1, 6'd0, 5'd1, 32'habc);
    chk("full.clear", 32'(bus.rob_full), 32'd0);
    chk("full.nextidx", 32'(bus.issue_index), 32'd0);

    // Mispredicted branch at idx5.
    rst = 1'b1; step(); rst = 0;
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_pred_taken = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.issue_rd = 5'(i + 1);
      bus.issue_is_branch = (i == 5);
      step();
    end
    bus.issue_valid = 1'b0; bus.issue_is_branch = 1'b0;
    cdb(6'd5, 32'h0); bus.cdb_taken = 1'b1; bus.cdb_target = 32'h1000; step();
    bus.cdb_taken = 1'b0; bus.cdb_target = 32'h0;
    for (int i = 0; i < 5; i++) begin
      cdb(6'(i), 32'h100 + 32'(i));
      step();
      if (i > 0) chk_commit($sformatf("br.c%0d", i - 1), 1'b1, 6'(i - 1), 5'(i), 32'h100 + 32'(i - 1));
    end
    bus.cdb_valid = 1'b0; step();
    chk_commit("br.c4", 1'b1, 6'd4, 5'd5, 32'h104);
    chk("br.noflush_yet", 32'(bus.flush), 32'd0);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd20;
    step();
    chk("br.flush", 32'(bus.flush), 32'd1);
    chk("br.flush_pc", bus.flush_pc, 32'h1000);
    chk("br.nocommit", 32'(bus.commit_valid), 32'd0);
    chk("br.idx", 32'(bus.issue_index), 32'd0);
    chk("br.full", 32'(bus.rob_full), 32'd0);
    cdb(6'd0, 32'h99); step();
    chk("br.flush_off", 32'(bus.flush), 32'd0);
    chk("br.flushcyc_idx", 32'(bus.issue_index), 32'd0);
    chk("br.flushcyc_commit", 32'(bus.commit_valid), 32'd0);
    clear_inputs();

    // Query bypass from the CDB.
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.issue_rd = 5'(i + 1);
      step();
    end
    bus.issue_valid = 1'b0;
    bus.query1_index = 6'd4; bus.query2_index = 6'd3;
    #1; chk("q.notready", 32'(bus.query1_ready), 32'd0);
    cdb(6'd4, 32'hdead);
    #1;
    chk("q.byp_ready", 32'(bus.query1_ready), 32'd1);
    chk("q.byp_value", bus.query1_value, 32'hdead);
    chk("q.other", 32'(bus.query2_ready), 32'd0);
    bus.query2_index = 6'd10;
    #1;
    chk("q.idle_ready", 32'(bus.query2_ready), 32'd0);
    chk("q.idle_value", bus.query2_value, 32'h0);
    step();
    bus.cdb_valid = 1'b0;
    #1;
    chk("q.stored_ready", 32'(bus.query1_ready), 32'd1);
    chk("q.stored_value", bus.query1_value, 32'hdead);

    // rdy=0 freezes everything while issue/CDB are active.
    cdb(6'd0, 32'h11); step();
    bus.cdb_valid = 1'b0; step();
    chk_commit("frz.pre", 1'b1, 6'd0, 5'd1, 32'h11);
    rdy = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    cdb(6'd1, 32'h22);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_commit($sformatf("frz.c%0d", i), 1'b1, 6'd0, 5'd1, 32'h11);
      chk($sformatf("frz.idx%0d", i), 32'(bus.issue_index), 32'd5);
    end
    bus.cdb_valid = 1'b0; bus.query1_index = 6'd1;
    #1; chk("frz.nowb", 32'(bus.query1_ready), 32'd0);
    rdy = 1'b1; bus.issue_valid = 1'b0;
    step();
    chk("frz.resume", 32'(bus.commit_valid), 32'd0);
    chk("frz.resume_idx", 32'(bus.issue_index), 32'd5);

    // Reset mid-stream.
    bus.issue_valid = 1'b1;
    cdb(6'd1, 32'h33);
    rst = 1'b1; step();
    chk_all_zero("midrst");
    rst = 1'b0;
    clear_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
